alu_operand_ctrl: RTL and testbench

Execute-stage operand controller for the 5-stage MIPS pipeline. It registers the decoder's AluSrc select into EX and generates per-operand forwarding selects for the ALU operand muxes. It detects load-use hazards, stalls IF/ID and inserts EX bubbles. It keeps an internal shadow pipeline of destination-register tags (EX/MEM/WB), so it needs no feedback from downstream stage registers beyond the advance rules defined here.

---
 rtl/alu_operand_ctrl_pkg.sv | 33 +++
 rtl/alu_operand_ctrl_tag_stage.sv | 33 +++
 rtl/alu_operand_ctrl.sv | 108 ++++++++++
 tb/tb_alu_operand_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_operand_ctrl_pkg.sv
// Shared encodings and helpers for the EX-stage operand controller.
// Holds the AluSrc and forwarding-select codes plus the forwarding priority function.
package alu_operand_ctrl_pkg;

    localparam logic [1:0] ALUSRC_R     = 2'b00;
    localparam logic [1:0] ALUSRC_I     = 2'b01;
    localparam logic [1:0] ALUSRC_ILL   = 2'b10;
    localparam logic [1:0] ALUSRC_SHIFT = 2'b11;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // The youngest producer wins. An EX producer is seen in MEM next cycle, so it selects FWD_MEM.
    // A load in EX never reaches this function on a matching source, because that case stalls.
    function automatic logic [1:0] fwd_sel(
        input logic       need,
        input logic [4:0] src,
        input logic       ex_hit_ok,
        input logic [4:0] ex_reg,
        input logic       mem_hit_ok,
        input logic [4:0] mem_reg
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (need && ex_hit_ok && ex_reg == src)
            sel = FWD_MEM;
        else if (need && mem_hit_ok && mem_reg == src)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/alu_operand_ctrl_tag_stage.sv
// One stage of the destination-register tag pipeline.
// A bubble load clears the stage, so a bubble never claims a register write.
module hazard_tag_stage #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_bubble,
    input  logic                  i_valid,
    input  logic                  i_wr_en,
    input  logic                  i_is_load,
    input  logic [REG_ADDR_W-1:0] i_wr_reg,
    output logic                  o_valid,
    output logic                  o_wr_en,
    output logic                  o_is_load,
    output logic [REG_ADDR_W-1:0] o_wr_reg
);

    always_ff @(posedge clk) begin
        if (rst || i_bubble) begin
            o_valid   <= 1'b0;
            o_wr_en   <= 1'b0;
            o_is_load <= 1'b0;
            o_wr_reg  <= '0;
        end else begin
            o_valid   <= i_valid;
            o_wr_en   <= i_wr_en;
            o_is_load <= i_is_load;
            o_wr_reg  <= i_wr_reg;
        end
    end

endmodule

// File: rtl/alu_operand_ctrl.sv
// EX-stage operand controller: registers AluSrc, generates forwarding selects and
// detects load-use hazards against a shadow EX/MEM/WB destination-tag pipeline.
module alu_operand_ctrl
    import alu_operand_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [1:0]             id_alu_src,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_wr_en,
    input  logic [REG_ADDR_W-1:0]  id_wr_reg,
    input  logic                   id_is_load,
    input  logic                   flush,
    output logic                   stall,
    output logic                   ex_valid,
    output logic [1:0]             ex_alu_src,
    output logic [1:0]             ex_fwd_a,
    output logic [1:0]             ex_fwd_b,
    output logic                   ex_illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic                  w_ex_wr_en, w_ex_is_load;
    logic [REG_ADDR_W-1:0] w_ex_wr_reg;
    logic                  w_mem_valid, w_mem_wr_en, w_mem_is_load;
    logic [REG_ADDR_W-1:0] w_mem_wr_reg;
    logic                  w_wb_valid, w_wb_wr_en, w_wb_is_load;
    logic [REG_ADDR_W-1:0] w_wb_wr_reg;

    logic                  w_use_a, w_use_b, w_need_a, w_need_b;
    logic [REG_ADDR_W-1:0] w_src_a;
    logic                  w_ex_load_hit, w_ex_fwd_ok, w_mem_fwd_ok;
    logic                  w_bubble;
    logic [1:0]            w_fwd_a, w_fwd_b;

    always_comb begin
        w_use_a = 1'b0;
        w_use_b = 1'b0;
        w_src_a = id_rs;
        case (id_alu_src)
            ALUSRC_R:     begin w_use_a = 1'b1; w_use_b = 1'b1; end
            ALUSRC_I:     w_use_a = 1'b1;
            ALUSRC_SHIFT: begin w_use_a = 1'b1; w_src_a = id_rt; end
            default:      ;
        endcase
    end

    // Register 0 is hardwired, so it never creates a dependency.
    assign w_need_a = w_use_a && (w_src_a != '0);
    assign w_need_b = w_use_b && (id_rt != '0);

    assign w_ex_load_hit = ex_valid && w_ex_wr_en && w_ex_is_load &&
                           ((w_need_a && w_ex_wr_reg == w_src_a) ||
                            (w_need_b && w_ex_wr_reg == id_rt));
    assign stall    = id_valid && !flush && w_ex_load_hit;
    assign w_bubble = !id_valid || flush || stall;

    assign w_ex_fwd_ok  = ex_valid && w_ex_wr_en && !w_ex_is_load;
    assign w_mem_fwd_ok = w_mem_valid && w_mem_wr_en;
    assign w_fwd_a = fwd_sel(w_need_a, w_src_a, w_ex_fwd_ok, w_ex_wr_reg, w_mem_fwd_ok, w_mem_wr_reg);
    assign w_fwd_b = fwd_sel(w_need_b, id_rt, w_ex_fwd_ok, w_ex_wr_reg, w_mem_fwd_ok, w_mem_wr_reg);

    hazard_tag_stage #(.REG_ADDR_W(REG_ADDR_W)) u_ex_tag (
        .clk(clk), .rst(rst), .i_bubble(w_bubble),
        .i_valid(1'b1), .i_wr_en(id_wr_en), .i_is_load(id_is_load), .i_wr_reg(id_wr_reg),
        .o_valid(ex_valid), .o_wr_en(w_ex_wr_en), .o_is_load(w_ex_is_load), .o_wr_reg(w_ex_wr_reg)
    );

    hazard_tag_stage #(.REG_ADDR_W(REG_ADDR_W)) u_mem_tag (
        .clk(clk), .rst(rst), .i_bubble(1'b0),
        .i_valid(ex_valid), .i_wr_en(w_ex_wr_en), .i_is_load(w_ex_is_load), .i_wr_reg(w_ex_wr_reg),
        .o_valid(w_mem_valid), .o_wr_en(w_mem_wr_en), .o_is_load(w_mem_is_load), .o_wr_reg(w_mem_wr_reg)
    );

    // WB producers need no forwarding (write-before-read regfile); the stage tracks retirement only.
    hazard_tag_stage #(.REG_ADDR_W(REG_ADDR_W)) u_wb_tag (
        .clk(clk), .rst(rst), .i_bubble(1'b0),
        .i_valid(w_mem_valid), .i_wr_en(w_mem_wr_en), .i_is_load(w_mem_is_load), .i_wr_reg(w_mem_wr_reg),
        .o_valid(w_wb_valid), .o_wr_en(w_wb_wr_en), .o_is_load(w_wb_is_load), .o_wr_reg(w_wb_wr_reg)
    );

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            ex_alu_src <= ALUSRC_R;
            ex_fwd_a   <= FWD_NONE;
            ex_fwd_b   <= FWD_NONE;
            ex_illegal <= 1'b0;
        end else begin
            ex_alu_src <= id_alu_src;
            ex_fwd_a   <= w_fwd_a;
            ex_fwd_b   <= w_fwd_b;
            ex_illegal <= (id_alu_src == ALUSRC_ILL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed bench for alu_operand_ctrl with a 2-bit stall counter so saturation is reachable.
module tb_alu_operand_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [1:0] id_alu_src;
    logic [4:0] id_rs, id_rt, id_wr_reg;
    logic       id_wr_en, id_is_load, flush;
    logic       stall, ex_valid, ex_illegal;
    logic [1:0] ex_alu_src, ex_fwd_a, ex_fwd_b;
    logic [1:0] stall_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    alu_operand_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_illegal(ex_illegal),
        .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [1:0] src, input logic [4:0] rs, input logic [4:0] rt,
                          input logic wen, input logic [4:0] wr, input logic ld, input logic fl);
        id_valid = v; id_alu_src = src; id_rs = rs; id_rt = rt;
        id_wr_en = wen; id_wr_reg = wr; id_is_load = ld; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ex(input string tag, input logic v, input logic [1:0] src,
                          input logic [1:0] fa, input logic [1:0] fb, input logic ill);
        chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, v});
        chk({tag, ".ex_alu_src"}, {30'd0, ex_alu_src}, {30'd0, src});
        chk({tag, ".ex_fwd_a"}, {30'd0, ex_fwd_a}, {30'd0, fa});
        chk({tag, ".ex_fwd_b"}, {30'd0, ex_fwd_b}, {30'd0, fb});
        chk({tag, ".ex_illegal"}, {31'd0, ex_illegal}, {31'd0, ill});
    endtask

    initial begin
        rst = 1'b1;
        id_set(0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_ex("reset", 0, 2'b00, 2'b00, 2'b00, 0);
        chk("reset.stall", {31'd0, stall}, 0);
        chk("reset.count", {30'd0, stall_count}, 0);

        // ADD r3 <- r1,r2 ; SUB rs=r3 rt=r3 forwards both from MEM
        id_set(1, 2'b00, 1, 2, 1, 3, 0, 0);
        tick();
        id_set(1, 2'b00, 3, 3, 1, 4, 0, 0);
        chk("sub.stall", {31'd0, stall}, 0);
        tick();
        chk_ex("sub", 1, 2'b00, 2'b01, 2'b01, 0);

        // ADDI r5 ; NOP ; SLL rt=r5 forwards operand 1 from WB
        id_set(1, 2'b01, 1, 0, 1, 5, 0, 0);
        tick();
        id_set(0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        id_set(1, 2'b11, 0, 5, 1, 6, 0, 0);
        tick();
        chk_ex("sll", 1, 2'b11, 2'b10, 2'b00, 0);

        // LW r7 ; ADD rs=r7 stalls once then forwards from WB
        id_set(1, 2'b01, 1, 0, 1, 7, 1, 0);
        tick();
        id_set(1, 2'b00, 7, 2, 1, 8, 0, 0);
        chk("lu.stall_on", {31'd0, stall}, 1);
        tick();
        chk_ex("lu.bubble", 0, 2'b00, 2'b00, 2'b00, 0);
        chk("lu.count", {30'd0, stall_count}, 1);
        chk("lu.stall_off", {31'd0, stall}, 0);
        tick();
        chk_ex("lu.add", 1, 2'b00, 2'b10, 2'b00, 0);
        chk("lu.count2", {30'd0, stall_count}, 1);

        // Flush beats a load-use stall
        id_set(1, 2'b01, 1, 0, 1, 7, 1, 0);
        tick();
        id_set(1, 2'b00, 7, 2, 1, 8, 0, 1);
        chk("flush.stall", {31'd0, stall}, 0);
        tick();
        chk_ex("flush", 0, 2'b00, 2'b00, 2'b00, 0);
        chk("flush.count", {30'd0, stall_count}, 1);

        // Writer to r0 then reader of r0: no forwarding
        id_set(1, 2'b00, 1, 2, 1, 0, 0, 0);
        tick();
        id_set(1, 2'b00, 0, 0, 1, 9, 0, 0);
        tick();
        chk_ex("r0", 1, 2'b00, 2'b00, 2'b00, 0);

        // Three more load-use pairs drive the 2-bit counter to saturation
        exp_cnt = 1;
        for (int k = 0; k < 3; k++) begin
            id_set(1, 2'b01, 1, 0, 1, 10, 1, 0);
            tick();
            id_set(1, 2'b00, 2, 10, 1, 11, 0, 0);
            chk("sat.stall", {31'd0, stall}, 1);
            tick();
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            chk("sat.count", {30'd0, stall_count}, exp_cnt[31:0]);
            tick();
            chk_ex("sat.add", 1, 2'b00, 2'b00, 2'b10, 0);
        end

        // Illegal AluSrc behind a load of its register: no stall, no forwarding
        id_set(1, 2'b01, 1, 0, 1, 3, 1, 0);
        tick();
        id_set(1, 2'b10, 3, 3, 1, 12, 0, 0);
        chk("ill.stall", {31'd0, stall}, 0);
        tick();
        chk_ex("ill", 1, 2'b10, 2'b00, 2'b00, 1);

        // Reset in the middle of a stall
        id_set(1, 2'b01, 1, 0, 1, 7, 1, 0);
        tick();
        id_set(1, 2'b00, 7, 7, 1, 8, 0, 0);
        chk("rst_mid.stall", {31'd0, stall}, 1);
        rst = 1'b1;
        tick();
        chk_ex("rst_mid", 0, 2'b00, 2'b00, 2'b00, 0);
        chk("rst_mid.count", {30'd0, stall_count}, 0);
        chk("rst_mid.stall_after", {31'd0, stall}, 0);
        rst = 1'b0;
        tick();
        chk_ex("rst_mid.replay", 1, 2'b00, 2'b00, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
